// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the byte-serial RAM arbiter:
// access sizes, controller states and port owners.
package mem_arbiter_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  // size code 3 is illegal and folds onto a word access
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Byte-wide RAM port arbiter: MEM has fixed priority over IF,
// every access is serialised into per-byte RAM cycles.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_request,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [31:0]           if_inst,
  input  logic                  mem_request,
  input  logic                  mem_we,
  input  logic [1:0]            mem_size,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic                  mem_done,
  output logic [31:0]           mem_rdata,
  input  logic [7:0]            ram_din,
  output logic [7:0]            ram_dout,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wr
);

  logic [1:0]            state;
  logic [2:0]            cnt;
  logic [2:0]            n;
  logic [ADDR_WIDTH-1:0] base;
  logic [31:0]           wdata;
  logic                  owner;
  logic [31:0]           dbuf;
  logic [31:0]           dbuf_next;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  rd_issue;

  assign cur_addr = base + ADDR_WIDTH'(cnt);
  assign rd_issue = (state == ST_READ) && (cnt < n);

  assign ram_wr   = (state == ST_WRITE);
  assign ram_addr = (rd_issue || ram_wr) ? cur_addr : '0;
  assign ram_dout = ram_wr ? 8'(wdata >> {cnt, 3'b000}) : 8'd0;

  assign if_done  = (state == ST_DONE) && (owner == OWN_IF);
  assign mem_done = (state == ST_DONE) && (owner == OWN_MEM);

  // RAM data lags its address by one cycle, so lane cnt-1 lands now
  always_comb begin
    dbuf_next = dbuf;
    for (int i = 0; i < 4; i++) begin
      if (cnt == 3'(i + 1)) dbuf_next[8*i +: 8] = ram_din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      n         <= '0;
      base      <= '0;
      wdata     <= '0;
      owner     <= OWN_IF;
      dbuf      <= '0;
      if_inst   <= '0;
      mem_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt  <= '0;
          dbuf <= '0;
          if (mem_request) begin
            owner <= OWN_MEM;
            n     <= size_bytes(mem_size);
            base  <= mem_addr;
            wdata <= mem_wdata;
            state <= mem_we ? ST_WRITE : ST_READ;
          end else if (if_request) begin
            owner <= OWN_IF;
            n     <= 3'd4;
            base  <= if_addr;
            wdata <= '0;
            state <= ST_READ;
          end
        end
        ST_READ: begin
          if (owner == OWN_IF && !if_request) begin
            state <= ST_IDLE;
          end else begin
            dbuf <= dbuf_next;
            cnt  <= cnt + 3'd1;
            if (cnt == n) begin
              state <= ST_DONE;
              if (owner == OWN_IF) if_inst <= dbuf_next;
              else mem_rdata <= dbuf_next;
            end
          end
        end
        ST_WRITE: begin
          cnt <= cnt + 3'd1;
          if (cnt == n - 3'd1) begin
            state     <= ST_DONE;
            mem_rdata <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter against a
// byte-array reference memory and cycle-count model.
module tb_mem_arbiter;

  logic        clk = 0;
  logic        rst;
  logic        if_request;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_inst;
  logic        mem_request;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_addr;
  logic        ram_wr;

  int passed = 0;
  int total  = 0;

  logic [7:0]  ram     [0:4095];
  logic [7:0]  ref_mem [0:4095];
  logic [31:0] tr_addr [0:39];
  logic        tr_wr   [0:39];
  logic [7:0]  tr_dout [0:39];
  logic [31:0] last_if;
  logic [31:0] last_mem;

  mem_arbiter #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .if_request(if_request), .if_addr(if_addr),
    .if_done(if_done), .if_inst(if_inst),
    .mem_request(mem_request), .mem_we(mem_we),
    .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done),
    .mem_rdata(mem_rdata), .ram_din(ram_din),
    .ram_dout(ram_dout), .ram_addr(ram_addr),
    .ram_wr(ram_wr)
  );

  always #5 clk = ~clk;

  // synchronous RAM: read data one cycle after address
  always @(posedge clk) begin
    ram_din <= ram[ram_addr[11:0]];
    if (ram_wr) ram[ram_addr[11:0]] <= ram_dout;
  end

  function automatic logic [31:0] model_read(input logic [31:0] a, input int nb);
    logic [31:0] d = '0;
    logic [31:0] ai;
    for (int i = 0; i < nb; i++) begin
      ai = a + 32'(i);
      d[8*i +: 8] = ref_mem[ai[11:0]];
    end
    return d;
  endfunction

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] v);
    ram[a[11:0]] = v;
    ref_mem[a[11:0]] = v;
  endtask

  // one access from IDLE; inputs scrambled after grant
  task automatic run_access(
    input bit is_mem, input bit we, input logic [1:0] size,
    input logic [31:0] addr, input logic [31:0] wd,
    input int drop_at,
    output int done_cyc, output logic [31:0] data);
    done_cyc = -1;
    data = 'x;
    if (is_mem) begin
      mem_request = 1; mem_we = we; mem_size = size;
      mem_addr = addr; mem_wdata = wd;
    end else begin
      if_request = 1; if_addr = addr;
    end
    for (int k = 0; k < 20; k++) begin
      if (k == drop_at) if_request = 0;
      if (k == 1) begin
        mem_addr = $urandom; mem_wdata = $urandom;
        mem_size = 2'($urandom); mem_we = ~mem_we;
        if_addr = $urandom;
      end
      @(negedge clk);
      tr_addr[k] = ram_addr; tr_wr[k] = ram_wr; tr_dout[k] = ram_dout;
      if ((is_mem ? mem_done : if_done) && done_cyc < 0) begin
        done_cyc = k;
        data = is_mem ? mem_rdata : if_inst;
        if (is_mem) mem_request = 0; else if_request = 0;
      end
      @(posedge clk); #1;
      if (done_cyc >= 0) break;
    end
    mem_request = 0;
    if_request = 0;
  endtask

  task automatic test_reset;
    rst = 0; if_request = 0; mem_request = 0;
    if_addr = 0; mem_we = 0; mem_size = 0; mem_addr = 0; mem_wdata = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    total++;
    if ({ram_wr, ram_addr, ram_dout} !== 41'd0) $display("FAIL reset_ram got wr=%b addr=%h dout=%h want 0", ram_wr, ram_addr, ram_dout);
    else passed++;
    total++;
    if ({if_done, mem_done} !== 2'b00) $display("FAIL reset_done got if=%b mem=%b want 0", if_done, mem_done);
    else passed++;
    total++;
    if ({if_inst, mem_rdata} !== 64'd0) $display("FAIL reset_data got inst=%h rdata=%h want 0", if_inst, mem_rdata);
    else passed++;
    @(posedge clk); #1;
    last_if = 0; last_mem = 0;
  endtask

  task automatic test_if_fetch;
    int dc; logic [31:0] d; bit anywr = 0; bit addr_ok = 1;
    poke(32'h100, 8'h13); poke(32'h101, 8'h05);
    poke(32'h102, 8'h00); poke(32'h103, 8'h00);
    run_access(0, 0, 2'd2, 32'h100, 0, -1, dc, d);
    for (int k = 0; k <= 6; k++) if (tr_wr[k]) anywr = 1;
    for (int k = 1; k <= 4; k++) if (tr_addr[k] !== 32'h100 + 32'(k - 1)) addr_ok = 0;
    total++;
    if (dc !== 6) $display("FAIL if_fetch_cycle got %0d want 6", dc); else passed++;
    total++;
    if (d !== 32'h00000513) $display("FAIL if_fetch_data got %h want 00000513", d); else passed++;
    total++;
    if (!addr_ok || anywr) $display("FAIL if_fetch_bus got addr1=%h wr=%b want 100.. wr=0", tr_addr[1], anywr);
    else passed++;
    last_if = 32'h00000513;
  endtask

  task automatic test_byte_load;
    int dc; logic [31:0] d;
    poke(32'h205, 8'hF0);
    run_access(1, 0, 2'd0, 32'h205, 0, -1, dc, d);
    total++;
    if (dc !== 3) $display("FAIL byte_load_cycle got %0d want 3", dc); else passed++;
    total++;
    if (d !== 32'h000000F0) $display("FAIL byte_load_data got %h want 000000f0", d); else passed++;
    last_mem = 32'hF0;
  endtask

  task automatic test_half_store;
    int dc; logic [31:0] d; logic [7:0] pre;
    pre = ram[12'h302];
    run_access(1, 1, 2'd1, 32'h300, 32'hABCD1234, -1, dc, d);
    ref_mem[12'h300] = 8'h34; ref_mem[12'h301] = 8'h12;
    total++;
    if ({tr_wr[1], tr_addr[1], tr_dout[1]} !== {1'b1, 32'h300, 8'h34})
      $display("FAIL half_store_c1 got wr=%b addr=%h dout=%h want 1 300 34", tr_wr[1], tr_addr[1], tr_dout[1]);
    else passed++;
    total++;
    if ({tr_wr[2], tr_addr[2], tr_dout[2]} !== {1'b1, 32'h301, 8'h12})
      $display("FAIL half_store_c2 got wr=%b addr=%h dout=%h want 1 301 12", tr_wr[2], tr_addr[2], tr_dout[2]);
    else passed++;
    total++;
    if (dc !== 3 || d !== 0) $display("FAIL half_store_done got cyc=%0d data=%h want 3 0", dc, d); else passed++;
    total++;
    if (ram[12'h302] !== pre || ram[12'h300] !== 8'h34 || ram[12'h301] !== 8'h12)
      $display("FAIL half_store_ram got %h %h %h want 34 12 %h", ram[12'h300], ram[12'h301], ram[12'h302], pre);
    else passed++;
    last_mem = 0;
  endtask

  task automatic test_simultaneous;
    int md = -1; int id = -1; logic [31:0] mdat, idat; bit ok = 1;
    mem_request = 1; mem_we = 0; mem_size = 2'd2; mem_addr = 32'h400;
    if_request = 1; if_addr = 32'h500;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      tr_addr[k] = ram_addr; tr_wr[k] = ram_wr;
      if (mem_done && md < 0) begin md = k; mdat = mem_rdata; mem_request = 0; end
      if (if_done && id < 0) begin id = k; idat = if_inst; if_request = 0; end
      @(posedge clk); #1;
      if (id >= 0) break;
    end
    mem_request = 0; if_request = 0;
    total++;
    if (md !== 6 || mdat !== model_read(32'h400, 4))
      $display("FAIL simul_mem got cyc=%0d data=%h want 6 %h", md, mdat, model_read(32'h400, 4));
    else passed++;
    total++;
    if (id !== 13 || idat !== model_read(32'h500, 4))
      $display("FAIL simul_if got cyc=%0d data=%h want 13 %h", id, idat, model_read(32'h500, 4));
    else passed++;
    for (int k = 1; k <= 4; k++) if (tr_addr[k] !== 32'h400 + 32'(k - 1)) ok = 0;
    for (int k = 8; k <= 11; k++) if (tr_addr[k] !== 32'h500 + 32'(k - 8)) ok = 0;
    for (int k = 0; k <= 13; k++) if (tr_wr[k]) ok = 0;
    total++;
    if (!ok) $display("FAIL simul_bus got addr1=%h addr8=%h want 400 500", tr_addr[1], tr_addr[8]);
    else passed++;
    last_mem = mdat; last_if = idat;
  endtask

  task automatic test_if_abort;
    int dc; logic [31:0] d;
    run_access(0, 0, 2'd2, 32'h100, 0, 3, dc, d);
    total++;
    if (dc !== -1) $display("FAIL if_abort_done got cyc=%0d want none", dc); else passed++;
    total++;
    if (tr_addr[4] !== 0 || tr_addr[5] !== 0) $display("FAIL if_abort_idle got addr4=%h want 0", tr_addr[4]);
    else passed++;
    total++;
    if (if_inst !== last_if) $display("FAIL if_abort_hold got %h want %h", if_inst, last_if); else passed++;
    run_access(0, 0, 2'd2, 32'h104, 0, -1, dc, d);
    total++;
    if (dc !== 6 || d !== model_read(32'h104, 4))
      $display("FAIL if_refetch got cyc=%0d data=%h want 6 %h", dc, d, model_read(32'h104, 4));
    else passed++;
    last_if = d;
  endtask

  task automatic test_reset_mid_store;
    int dc; logic [31:0] d; bit bad = 0; logic [7:0] pre2;
    pre2 = ram[12'h602];
    mem_request = 1; mem_we = 1; mem_size = 2'd2;
    mem_addr = 32'h600; mem_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    rst = 1; mem_request = 0;
    ref_mem[12'h600] = 8'hEF; ref_mem[12'h601] = 8'hBE;
    @(negedge clk);
    total++;
    if ({ram_wr, ram_addr, ram_dout, mem_done, if_done, mem_rdata, if_inst} !== 107'd0)
      $display("FAIL rst_mid_outputs got wr=%b addr=%h rdata=%h inst=%h want 0", ram_wr, ram_addr, mem_rdata, if_inst);
    else passed++;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ram_wr || mem_done) bad = 1;
    end
    total++;
    if (bad) $display("FAIL rst_mid_quiet got activity=1 want 0"); else passed++;
    @(posedge clk); #1;
    total++;
    if (ram[12'h602] !== pre2 || ram[12'h601] !== 8'hBE)
      $display("FAIL rst_mid_ram got %h %h want be %h", ram[12'h601], ram[12'h602], pre2);
    else passed++;
    run_access(1, 0, 2'd2, 32'h600, 0, -1, dc, d);
    total++;
    if (dc !== 6 || d !== model_read(32'h600, 4))
      $display("FAIL rst_mid_reload got cyc=%0d data=%h want 6 %h", dc, d, model_read(32'h600, 4));
    else passed++;
    last_mem = d; last_if = 0;
  endtask

  task automatic test_random;
    int dc; logic [31:0] d, a, wd, exp; logic [1:0] sz;
    bit is_mem, we, bus_ok; int nb, exp_cyc;
    for (int t = 0; t < 40; t++) begin
      is_mem = 1'($urandom);
      we = is_mem & 1'($urandom);
      sz = 2'($urandom);
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                      : 32'($urandom_range(0, 4095));
      wd = $urandom;
      nb = is_mem ? nbytes(sz) : 4;
      exp = we ? 32'd0 : model_read(a, nb);
      exp_cyc = we ? nb + 1 : nb + 2;
      run_access(is_mem, we, sz, a, wd, -1, dc, d);
      bus_ok = 1;
      for (int i = 0; i < nb; i++) begin
        if (tr_addr[i+1] !== a + 32'(i) || tr_wr[i+1] !== we) bus_ok = 0;
        if (we && tr_dout[i+1] !== wd[8*i +: 8]) bus_ok = 0;
      end
      if (we) for (int i = 0; i < nb; i++) ref_mem[12'(a + 32'(i))] = wd[8*i +: 8];
      total++;
      if (dc !== exp_cyc || d !== exp)
        $display("FAIL rand_%0d got cyc=%0d data=%h want %0d %h", t, dc, d, exp_cyc, exp);
      else passed++;
      total++;
      if (!bus_ok) $display("FAIL rand_bus_%0d got addr1=%h wr1=%b want %h %b", t, tr_addr[1], tr_wr[1], a, we);
      else passed++;
      if (is_mem) last_mem = exp; else last_if = exp;
      total++;
      if (if_inst !== last_if || mem_rdata !== last_mem)
        $display("FAIL rand_hold_%0d got %h %h want %h %h", t, if_inst, mem_rdata, last_if, last_mem);
      else passed++;
    end
    total++;
    if (model_read(32'hFFFFFFFC, 4) !== {ram[12'hFFF], ram[12'hFFE], ram[12'hFFD], ram[12'hFFC]})
      $display("FAIL rand_ram_top got %h want %h", {ram[12'hFFF], ram[12'hFFE], ram[12'hFFD], ram[12'hFFC]}, model_read(32'hFFFFFFFC, 4));
    else passed++;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i] = 8'(i * 37 + 11);
      ref_mem[i] = 8'(i * 37 + 11);
    end
    test_reset;
    test_if_fetch;
    test_byte_load;
    test_half_store;
    test_simultaneous;
    test_if_abort;
    test_reset_mid_store;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
